// File: rtl/fifo_stream_arbiter.sv
// Round-robin merge of N_SRC first-word-fall-through source FIFOs into one FWFT read port.
// Latency: data/empty/read-forwarding are combinational from the registered grant; a new grant lands one cycle after its request.
// Backpressure: FIFO_READ reaches only the granted source while it is non-empty; reads against an empty merged port are dropped.
module fifo_stream_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DEF_BURST = 16,
  parameter int VERSION   = 1
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [15:0]          BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  output logic [N_SRC-1:0]     IN_FIFO_READ,
  input  logic [N_SRC-1:0]     IN_FIFO_EMPTY,
  input  logic [32*N_SRC-1:0]  IN_FIFO_DATA,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA,
  output logic [N_SRC-1:0]     GRANT
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [7:0]        burst_q;
  logic [N_SRC-1:0]  en_mask_q;
  logic [15:0]       cnt_q [N_SRC];

  logic [31:0]       src_dat [N_SRC];
  logic [N_SRC-1:0]  grant_vec;
  logic [N_SRC-1:0]  req;
  logic              granted;
  logic              accept;
  logic              rel_hold;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     pick_base;
  logic [IW-1:0]     scan_idx;
  logic              cnt_clr;
  logic [IW-1:0]     cnt_sel;
  logic [7:0]        rd_mux;

  // Slice the flat source data bus into per-source words
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src_dat[i] = IN_FIFO_DATA[32*i +: 32];
  end

  // Output datapath steered purely by the registered grant
  always_comb begin
    granted   = (state_q == HOLD);
    grant_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      grant_vec[i] = granted && (gidx_q == IW'(i));
    end
    FIFO_EMPTY = granted ? IN_FIFO_EMPTY[gidx_q] : 1'b1;
    FIFO_DATA  = granted ? src_dat[gidx_q] : 32'h0;
  end

  // A read only counts when the merged port actually has a word
  assign accept       = FIFO_READ & ~FIFO_EMPTY;
  assign IN_FIFO_READ = grant_vec & {N_SRC{accept}};
  assign GRANT        = grant_vec;
  assign req          = ~IN_FIFO_EMPTY & en_mask_q;

  // Round-robin pick: first requester after the base, wrapping so the base itself is last
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    scan_idx  = '0;
    pick_base = granted ? gidx_q : rr_q;
    for (int k = N_SRC; k >= 1; k--) begin
      scan_idx = IW'((int'(pick_base) + k) % N_SRC);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Grant FSM: release on burst limit, source empty or source disabled, re-arbitrating at the same edge
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    bcnt_d   = bcnt_q;
    rel_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = HOLD;
          gidx_d  = pick_idx;
          bcnt_d  = 8'd0;
        end
      end
      HOLD: begin
        rel_hold = (accept && (burst_q != 8'd0) && (bcnt_q == burst_q - 8'd1))
                 || IN_FIFO_EMPTY[gidx_q]
                 || !en_mask_q[gidx_q];
        if (rel_hold) begin
          rr_d   = gidx_q;
          bcnt_d = 8'd0;
          if (pick_vld) begin
            gidx_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; pointer starts at the last source so source 0 wins first
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      rr_q    <= IW'(N_SRC - 1);
      bcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign cnt_clr = BUS_WR && (BUS_ADD == 16'd0);

  // Configuration registers written from the local bus
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      en_mask_q <= '1;
      burst_q   <= 8'(DEF_BURST);
    end else if (BUS_WR) begin
      if (BUS_ADD == 16'd1) en_mask_q <= BUS_DATA_IN[N_SRC-1:0];
      if (BUS_ADD == 16'd2) burst_q   <= BUS_DATA_IN;
    end
  end

  // Per-source word counters; a bus clear overrides a read landing in the same cycle
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || cnt_clr) begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= 16'd0;
    end else if (accept) begin
      cnt_q[gidx_q] <= cnt_q[gidx_q] + 16'd1;
    end
  end

  // Read-back mux for the register map; unmapped addresses return zero
  always_comb begin
    rd_mux  = 8'h00;
    cnt_sel = IW'((BUS_ADD - 16'd4) >> 1);
    if (BUS_ADD == 16'd0) begin
      rd_mux = 8'(VERSION);
    end else if (BUS_ADD == 16'd1) begin
      rd_mux[N_SRC-1:0] = en_mask_q;
    end else if (BUS_ADD == 16'd2) begin
      rd_mux = burst_q;
    end else if (BUS_ADD == 16'd3) begin
      rd_mux[N_SRC-1:0] = grant_vec;
    end else if (BUS_ADD < 16'(4 + 2*N_SRC)) begin
      rd_mux = BUS_ADD[0] ? cnt_q[cnt_sel][15:8] : cnt_q[cnt_sel][7:0];
    end
  end

  // Registered read data, valid the cycle after the read strobe
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      BUS_DATA_OUT <= 8'h00;
    end else if (BUS_RD) begin
      BUS_DATA_OUT <= rd_mux;
    end
  end

endmodule
